// File: rtl/screen_painter_pkg.sv
// Shared constants, screen codes and FSM state encoding for the full-screen painter.
package screen_painter_pkg;

    // Framebuffer geometry (160x120 VGA adapter framebuffer).
    localparam int FB_WIDTH  = 160;
    localparam int FB_HEIGHT = 120;

    // Port widths.
    localparam int ADDR_W = 15;
    localparam int X_W    = 8;
    localparam int Y_W    = 7;
    localparam int COL_W  = 3;

    // Screen codes. SCR_INVALID never matches a decoded target,
    // so it forces a paint.
    localparam logic [2:0] SCR_CLEAR   = 3'd0;
    localparam logic [2:0] SCR_TITLE1  = 3'd1;
    localparam logic [2:0] SCR_TITLE2  = 3'd2;
    localparam logic [2:0] SCR_WIN     = 3'd3;
    localparam logic [2:0] SCR_LOSE    = 3'd4;
    localparam logic [2:0] SCR_INVALID = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PAINT = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Image ROM select for a screen code: title1=0, title2=1, win=2, lose=3.
    // The clear screen ignores ROM data, so it simply parks on 0.
    function automatic logic [1:0] code_to_sel(input logic [2:0] code);
        logic [1:0] sel;
        sel = 2'd0;
        case (code)
            SCR_TITLE1: sel = 2'd0;
            SCR_TITLE2: sel = 2'd1;
            SCR_WIN:    sel = 2'd2;
            SCR_LOSE:   sel = 2'd3;
            default:    sel = 2'd0;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/screen_scan_counter.sv
// Raster scan counters: sx/sy with row wrap, last-pixel flag, and the
// registered ROM address that always equals sy*WIDTH + sx.
module screen_scan_counter
    import screen_painter_pkg::*;
#(
    parameter int WIDTH  = FB_WIDTH,
    parameter int HEIGHT = FB_HEIGHT
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              clear,
    input  logic              advance,
    output logic [X_W-1:0]    sx,
    output logic [Y_W-1:0]    sy,
    output logic              last,
    output logic [ADDR_W-1:0] rom_addr
);

    logic at_row_end;
    logic at_last_row;

    // Scan position decode.
    always_comb begin
        at_row_end  = (sx == X_W'(WIDTH - 1));
        at_last_row = (sy == Y_W'(HEIGHT - 1));
        last        = at_row_end && at_last_row;
    end

    // Raster counters. The scan is linear, so the address tracks
    // sy*WIDTH + sx by incrementing instead of multiplying, and returns
    // to 0 after the final pixel so it never leaves the framebuffer range.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            sx       <= '0;
            sy       <= '0;
            rom_addr <= '0;
        end else if (clear) begin
            sx       <= '0;
            sy       <= '0;
            rom_addr <= '0;
        end else if (advance) begin
            if (at_row_end) begin
                sx <= '0;
                sy <= at_last_row ? '0 : sy + Y_W'(1);
            end else begin
                sx <= sx + X_W'(1);
            end
            rom_addr <= last ? '0 : rom_addr + ADDR_W'(1);
        end
    end

endmodule

// File: rtl/screen_painter.sv
// Full-screen painter: decodes the title FSM's screen selects and, whenever
// the selected screen differs from the one last painted, sweeps the whole
// framebuffer from the selected image ROM or with a solid clear colour.
//
// Output handshake: plot is a one-cycle write strobe with x/y/colour valid in
// the same cycle; there is no back-pressure. busy is high from the first
// address cycle through the last plot, and done pulses the cycle after it.
module screen_painter
    import screen_painter_pkg::*;
#(
    parameter int         WIDTH        = FB_WIDTH,
    parameter int         HEIGHT       = FB_HEIGHT,
    parameter logic [2:0] CLEAR_COLOUR = 3'b000
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              title1,
    input  logic              title2,
    input  logic              winend,
    input  logic              loseend,
    input  logic              titleoff,
    input  logic [COL_W-1:0]  rom_data,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [1:0]        rom_sel,
    output logic [X_W-1:0]    x,
    output logic [Y_W-1:0]    y,
    output logic [COL_W-1:0]  colour,
    output logic              plot,
    output logic              busy,
    output logic              done,
    output state_t            dbg_state
);

    state_t         state_q, state_d;
    logic [2:0]     target_q, target_d;
    logic [2:0]     painted_q;
    logic [2:0]     active_q;
    logic           scan_clear, scan_adv, latch_active, commit_painted;
    logic [X_W-1:0] sx;
    logic [Y_W-1:0] sy;
    logic           scan_last;
    logic [X_W-1:0] px_q;
    logic [Y_W-1:0] py_q;
    logic           pvalid_q;

    screen_scan_counter #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT)
    ) u_scan (
        .clk      (clk),
        .resetn   (resetn),
        .clear    (scan_clear),
        .advance  (scan_adv),
        .sx       (sx),
        .sy       (sy),
        .last     (scan_last),
        .rom_addr (rom_addr)
    );

    // Priority decode of the screen selects; with nothing selected the
    // previous target is held.
    always_comb begin
        target_d = target_q;
        if (loseend)       target_d = SCR_LOSE;
        else if (winend)   target_d = SCR_WIN;
        else if (title1)   target_d = SCR_TITLE1;
        else if (title2)   target_d = SCR_TITLE2;
        else if (titleoff) target_d = SCR_CLEAR;
    end

    // Target, painted and active screen registers. painted resets to an
    // invalid code so the first decoded target always gets painted.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            target_q  <= SCR_INVALID;
            painted_q <= SCR_INVALID;
            active_q  <= SCR_CLEAR;
        end else begin
            target_q <= target_d;
            if (latch_active)   active_q  <= target_q;
            if (commit_painted) painted_q <= active_q;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!resetn) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    // Next state and control strobes. The target is only compared in
    // S_IDLE, so a change mid-sweep waits for the current sweep to finish.
    always_comb begin
        state_d        = state_q;
        scan_clear     = 1'b0;
        scan_adv       = 1'b0;
        latch_active   = 1'b0;
        commit_painted = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (target_q != painted_q) begin
                    latch_active = 1'b1;
                    scan_clear   = 1'b1;
                    state_d      = S_PAINT;
                end
            end
            S_PAINT: begin
                scan_adv = 1'b1;
                if (scan_last) state_d = S_FLUSH;
            end
            S_FLUSH: begin
                state_d = S_DONE;
            end
            S_DONE: begin
                commit_painted = 1'b1;
                state_d        = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // One-stage pixel pipeline aligned with the synchronous ROM read.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            px_q     <= '0;
            py_q     <= '0;
            pvalid_q <= 1'b0;
        end else begin
            px_q     <= sx;
            py_q     <= sy;
            pvalid_q <= (state_q == S_PAINT);
        end
    end

    // Output drive: pixel from the pipeline register, colour from the ROM
    // (or the clear colour), status straight from the state.
    always_comb begin
        x         = px_q;
        y         = py_q;
        plot      = pvalid_q;
        colour    = '0;
        if (pvalid_q)
            colour = (active_q == SCR_CLEAR) ? CLEAR_COLOUR : rom_data;
        rom_sel   = code_to_sel(active_q);
        busy      = (state_q == S_PAINT) || (state_q == S_FLUSH);
        done      = (state_q == S_DONE);
        dbg_state = state_q;
    end

endmodule

// File: tb/tb_screen_painter.sv
// Randomized scoreboard bench for screen_painter. The framebuffer height is
// shortened to keep the run short; rows keep their full 160-pixel width.
module tb_screen_painter;
  import screen_painter_pkg::*;

  localparam int W = 160;
  localparam int H = 30;
  localparam logic [2:0] CLR = 3'b000;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic title1 = 1'b0, title2 = 1'b0, winend = 1'b0, loseend = 1'b0, titleoff = 1'b0;
  logic [2:0] rom_data = 3'd0;
  logic [14:0] rom_addr;
  logic [1:0] rom_sel;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic plot, busy, done;
  state_t dbg_state;

  always #5 clk = ~clk;

  screen_painter #(.WIDTH(W), .HEIGHT(H), .CLEAR_COLOUR(CLR)) dut (
    .clk(clk), .resetn(resetn),
    .title1(title1), .title2(title2), .winend(winend), .loseend(loseend), .titleoff(titleoff),
    .rom_data(rom_data), .rom_addr(rom_addr), .rom_sel(rom_sel),
    .x(x), .y(y), .colour(colour), .plot(plot), .busy(busy), .done(done),
    .dbg_state(dbg_state)
  );

  // ---------------- image ROM model ----------------
  logic [31:0] salt [4];

  function automatic logic [2:0] rom_fn(input logic [1:0] sel, input logic [14:0] addr);
    logic [31:0] h;
    h = (32'(addr) * 32'd2654435761) ^ salt[sel];
    h = h ^ (h >> 13);
    return h[2:0];
  endfunction

  always @(posedge clk) rom_data <= rom_fn(rom_sel, rom_addr);

  // ---------------- scoreboard ----------------
  // entry: [21:14] x, [13:7] y, [6:4] colour, [3:2] rom_sel, [1] check sel, [0] last
  logic [21:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int plot_count = 0;
  logic done_pending = 1'b0;
  logic [14:0] prev_addr = 15'd0;
  logic [2:0] m_target = SCR_INVALID;
  logic [2:0] m_sched = SCR_INVALID;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: a full raster of the screen, row-major, colour from the image
  // for that screen or the clear colour.
  task automatic push_sweep(input logic [2:0] code);
    logic [1:0] sel;
    logic [2:0] c;
    logic [14:0] a;
    sel = (code == SCR_CLEAR) ? 2'd0 : 2'(code - 3'd1);
    for (int yy = 0; yy < H; yy++) begin
      for (int xx = 0; xx < W; xx++) begin
        a = 15'(yy * W + xx);
        c = (code == SCR_CLEAR) ? CLR : rom_fn(sel, a);
        exp_q.push_back({8'(xx), 7'(yy), c, sel, (code != SCR_CLEAR),
                         (yy == H - 1 && xx == W - 1)});
      end
    end
  endtask

  // Model of the select decode; a new sweep is expected whenever the
  // decoded screen differs from the last one scheduled.
  task automatic model_update();
    logic [2:0] c;
    if (loseend)       c = SCR_LOSE;
    else if (winend)   c = SCR_WIN;
    else if (title1)   c = SCR_TITLE1;
    else if (title2)   c = SCR_TITLE2;
    else if (titleoff) c = SCR_CLEAR;
    else               c = m_target;
    m_target = c;
    if (c != m_sched) begin
      push_sweep(c);
      m_sched = c;
    end
  endtask

  // Monitor: pops and compares on every plot, and checks done placement.
  always @(negedge clk) begin
    logic [21:0] e;
    if (done_pending) begin
      check("done_after_last_plot", 32'(done), 32'd1);
      done_pending = 1'b0;
    end else if (done) begin
      check("unexpected_done", 32'(done), 32'd0);
    end
    if (plot) begin
      if (exp_q.size() == 0) begin
        check("unexpected_plot", 32'(plot), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("x", 32'(x), 32'(e[21:14]));
        check("y", 32'(y), 32'(e[13:7]));
        check("colour", 32'(colour), 32'(e[6:4]));
        if (e[1]) check("rom_sel", 32'(rom_sel), 32'(e[3:2]));
        check("rom_addr_prev_cycle", 32'(prev_addr), 32'(e[21:14]) + 32'(e[13:7]) * W);
        check("busy_during_plot", 32'(busy), 32'd1);
        if (e[0]) done_pending = 1'b1;
        plot_count++;
      end
    end
    prev_addr = rom_addr;
  end

  // ---------------- driver tasks ----------------
  task automatic set_sel(input logic t1, input logic t2, input logic w, input logic l, input logic off);
    @(posedge clk); #1;
    title1 = t1; title2 = t2; winend = w; loseend = l; titleoff = off;
    model_update();
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || done_pending) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0 || done_pending)
      check("drain_timeout", 32'(exp_q.size()), 32'd0);
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_plots(input int target, input int budget);
    int n;
    n = 0;
    while (plot_count < target && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (plot_count < target) check("plot_wait_timeout", 32'(plot_count), 32'(target));
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int base, at;
    for (int i = 0; i < 4; i++) salt[i] = $urandom;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_x", 32'(x), 32'd0);
    check("reset_y", 32'(y), 32'd0);
    check("reset_colour", 32'(colour), 32'd0);
    check("reset_plot", 32'(plot), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_rom_addr", 32'(rom_addr), 32'd0);
    check("reset_rom_sel", 32'(rom_sel), 32'd0);
    check("reset_state", 32'(dbg_state), 32'(S_IDLE));
    @(posedge clk); #1;
    resetn = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_after_reset_busy", 32'(busy), 32'd0);

    // title1 sweep, switched to title2 part-way through
    base = plot_count;
    set_sel(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    at = $urandom_range(1000, 3000);
    wait_plots(base + at, 10000);
    title1 = 1'b0; title2 = 1'b1;
    model_update();
    wait_drain(20000);

    // win and lose together: lose has priority; lower selects randomly set too
    set_sel(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1, 1'b1,
            1'($urandom_range(0, 1)));
    wait_drain(10000);

    // win alone, then nothing selected for a long stretch
    set_sel(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    wait_drain(10000);
    set_sel(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      check("idle_busy", 32'(busy), 32'd0);
    end

    // clear screen, interrupted by reset, then a full repaint
    base = plot_count;
    set_sel(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    at = $urandom_range(1500, 3500);
    wait_plots(base + at, 10000);
    resetn = 1'b0;
    @(posedge clk); #1;
    exp_q.delete();
    done_pending = 1'b0;
    m_target = SCR_INVALID;
    m_sched = SCR_INVALID;
    @(negedge clk);
    check("reset_mid_sweep_plot", 32'(plot), 32'd0);
    check("reset_mid_sweep_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    model_update();
    check("repaint_scheduled", 32'(exp_q.size()), 32'(W * H));
    wait_drain(10000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1);
  end

endmodule

// File: doc/screen_painter.md
# screen_painter

Full-screen painter downstream of the title/end-screen FSM. It decodes the FSM's one-hot screen-select outputs (title1, title2, winend, loseend, titleoff) into a screen code. Whenever that code differs from the screen last painted, it sweeps every pixel of the 160x120 VGA framebuffer, either from the selected image ROM or with a solid clear colour. Its x/y/colour/plot outputs feed the VGA adapter through the top-level draw mux; busy tells the mux to give this block the bus.

## Interface
- WIDTH, 160, pixels per row
- HEIGHT, 120, rows
- CLEAR_COLOUR, 3'b000, colour painted for the gameplay (titleoff) screen
- clk  in  1  system clock
- resetn  in  1  synchronous active-low reset, sampled on the rising edge of clk
- title1, title2, winend, loseend, titleoff  in  1 each  screen selects from the title FSM
- rom_data  in  3  pixel from the selected image ROM; valid one cycle after rom_addr (synchronous ROM)
- rom_addr  out  15  pixel address, y*WIDTH + x
- rom_sel  out  2  image select: 0 title1, 1 title2, 2 win, 3 lose
- x  out  8  framebuffer column
- y  out  7  framebuffer row
- colour  out  3  pixel colour
- plot  out  1  write strobe to the VGA adapter
- busy  out  1  high while the sweep is in progress
- done  out  1  one-cycle pulse after the last plot

## Operation
- Target code decode uses this priority: loseend > winend > title1 > title2 > titleoff.
  - Codes: LOSE=4, WIN=3, TITLE1=1, TITLE2=2, CLEAR=0.
  - If no select is high, the target holds its previous value.
- A painted-code register resets to 7 (invalid), so the first target after reset always triggers a paint.
- State machine: S_IDLE, S_PAINT, S_FLUSH, S_DONE.
  - S_IDLE: if target != painted, latch the target into the active code, clear the scan counters, and go to S_PAINT.
  - S_PAINT: issue rom_addr for the scan point (sx, sy) each cycle.
    - Advance sx. At WIDTH-1, wrap sx to 0 and increment sy.
    - After issuing (WIDTH-1, HEIGHT-1), go to S_FLUSH.
  - S_FLUSH: drain the final pipeline slot, then go to S_DONE.
  - S_DONE: pulse done, set painted to the active code, return to S_IDLE.
- Pixel pipeline is one stage: sx, sy and a valid bit are registered alongside the ROM access. Outputs x, y and plot come from that register.
- colour is rom_data for codes 1–4 and CLEAR_COLOUR for code 0. For code 0, rom_addr still sweeps but rom_data is ignored.
- The target is not resampled during a sweep. A target change mid-sweep is handled after the current sweep finishes: S_IDLE compares again and starts a new sweep.
- rom_addr is computed as sy*WIDTH + sx in 15 bits, maximum 19199. No overflow.

## Timing
- Reset values:
  - Outputs: x=0, y=0, colour=0, plot=0, busy=0, done=0, rom_addr=0, rom_sel=0.
  - State: S_IDLE, painted=7.
- Paint start: one cycle in S_IDLE after the target mismatch is seen.
- Per-pixel timing: address issued in cycle n; plot, x, y and colour valid in cycle n+1.
- Sweep length: 19200 address cycles plus 1 flush cycle, giving exactly 19200 plot pulses.
  - busy is high on every cycle from the first address through the last plot.
  - done pulses in the cycle immediately after the last plot.
  - Minimum gap from done to the next sweep's first address is 1 cycle (the S_IDLE compare).
- Title flash period (20M cycles) is far longer than the 19202-cycle sweep, so no flash edge is lost.
- Reset mid-sweep: plot=0 and busy=0 in the next cycle. The sweep is abandoned, and painted=7 forces a repaint of the current target.

## Structure
- Shared package holds:
  - Screen code constants (SCR_CLEAR, SCR_TITLE1, SCR_TITLE2, SCR_WIN, SCR_LOSE, SCR_INVALID).
  - FB_WIDTH and FB_HEIGHT.
  - The state encodings.
- One natural sub-module, screen_scan_counter: sx/sy counters with wrap and last-pixel flag, plus the registered rom_addr.
- Decode, FSM and output pipeline stay in screen_painter.

## Test plan
- Reset, then title1=1 held:
  - 19200 plots, first at (0,0) carrying rom_data of address 0, last at (159,119) with rom_addr 19199 issued one cycle earlier.
  - done pulses one cycle after the last plot; rom_sel=0.
- Switch title1→title2 at pixel 5000 of the sweep:
  - The title1 sweep completes all 19200 plots.
  - done pulses, then a title2 sweep starts with rom_sel=1.
- winend=1 and loseend=1 together: sweep uses rom_sel=3 (lose).
- After the win screen is painted, all selects go to 0 for 100k cycles: no plot and busy stays 0.
- titleoff=1: 19200 plots, all with colour=CLEAR_COLOUR regardless of the rom_data pattern.
- resetn=0 for one cycle at pixel 8000: plot=0 the next cycle; after release a full sweep restarts at (0,0).
